// File: rtl/timer_counter.sv
`default_nettype none
// ============================================================================
// Module   : timer_counter
// Brief    : Memory-mapped countdown timer with one-shot and auto-reload
//            modes. Registers CTRL/PRESET/COUNT sit on the system bridge.
//            The interrupt request goes to CP0.
// Revision : 1.0 - initial release
// ============================================================================
module timer_counter #(
    parameter int COUNT_W = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  addr,
    input  logic        we,
    input  logic [31:0] din,
    output logic [31:0] dout,
    output logic        irq
);

    localparam logic [1:0] c_ST_IDLE     = 2'd0;
    localparam logic [1:0] c_ST_LOAD     = 2'd1;
    localparam logic [1:0] c_ST_CNT      = 2'd2;
    localparam logic [1:0] c_ST_INT      = 2'd3;

    localparam logic [1:0] c_ADDR_CTRL   = 2'd0;
    localparam logic [1:0] c_ADDR_PRESET = 2'd1;
    localparam logic [1:0] c_ADDR_COUNT  = 2'd2;

    localparam logic [1:0] c_MODE_RELOAD = 2'b01;

    logic [1:0]         r_state;
    logic               r_en;
    logic [1:0]         r_mode;
    logic               r_im;
    logic [COUNT_W-1:0] r_preset;
    logic [COUNT_W-1:0] r_count;
    logic               r_irq_pending;

    logic [1:0]         w_state_nxt;
    logic [COUNT_W-1:0] w_count_nxt;
    logic               w_en_fsm;
    logic               w_set_pend;
    logic               w_clr_pend;
    logic               w_wr_ctrl;
    logic               w_wr_preset;
    logic               w_en_nxt;
    logic [1:0]         w_mode_nxt;
    logic               w_im_nxt;
    logic [COUNT_W-1:0] w_preset_nxt;
    logic               w_pending_nxt;
    logic [31:0]        w_preset_ext;
    logic [31:0]        w_count_ext;

    assign w_wr_ctrl   = we && (addr == c_ADDR_CTRL);
    assign w_wr_preset = we && (addr == c_ADDR_PRESET);

    // Zero-extend the counter-width registers onto the 32-bit read bus.
    generate
        if (COUNT_W < 32) begin : g_ext_pad
            assign w_preset_ext = {{(32-COUNT_W){1'b0}}, r_preset};
            assign w_count_ext  = {{(32-COUNT_W){1'b0}}, r_count};
        end else begin : g_ext_full
            assign w_preset_ext = r_preset;
            assign w_count_ext  = r_count;
        end
    endgenerate

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and counter logic. EN is sampled from the register, so a
    // CTRL write only steers the FSM from the following cycle on.
    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_en_fsm    = r_en;
        w_set_pend  = 1'b0;
        w_clr_pend  = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (r_en) begin
                    w_state_nxt = c_ST_LOAD;
                end
            end
            c_ST_LOAD: begin
                w_count_nxt = r_preset;
                w_state_nxt = r_en ? c_ST_CNT : c_ST_IDLE;
            end
            c_ST_CNT: begin
                if (!r_en) begin
                    w_state_nxt = c_ST_IDLE;
                end else if (r_count != '0) begin
                    w_count_nxt = r_count - COUNT_W'(1);
                end else begin
                    w_state_nxt = c_ST_INT;
                    w_set_pend  = 1'b1;
                end
            end
            c_ST_INT: begin
                // Mode is the value held before any write in this cycle.
                if (r_mode == c_MODE_RELOAD) begin
                    w_state_nxt = c_ST_LOAD;
                    w_clr_pend  = 1'b1;
                end else begin
                    w_state_nxt = c_ST_IDLE;
                    w_en_fsm    = 1'b0;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    // Register-file next values: software writes override the FSM's EN
    // auto-clear, and any CTRL/PRESET write acknowledges a pending IRQ.
    always_comb begin
        w_en_nxt      = w_wr_ctrl ? din[0]   : w_en_fsm;
        w_mode_nxt    = w_wr_ctrl ? din[2:1] : r_mode;
        w_im_nxt      = w_wr_ctrl ? din[3]   : r_im;
        w_preset_nxt  = w_wr_preset ? din[COUNT_W-1:0] : r_preset;
        w_pending_nxt = r_irq_pending;
        if (w_wr_ctrl || w_wr_preset) begin
            w_pending_nxt = 1'b0;
        end else if (w_set_pend) begin
            w_pending_nxt = 1'b1;
        end else if (w_clr_pend) begin
            w_pending_nxt = 1'b0;
        end
    end

    // Data registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_en          <= 1'b0;
            r_mode        <= 2'b00;
            r_im          <= 1'b0;
            r_preset      <= '0;
            r_count       <= '0;
            r_irq_pending <= 1'b0;
        end else begin
            r_en          <= w_en_nxt;
            r_mode        <= w_mode_nxt;
            r_im          <= w_im_nxt;
            r_preset      <= w_preset_nxt;
            r_count       <= w_count_nxt;
            r_irq_pending <= w_pending_nxt;
        end
    end

    // Combinational read mux; offset 3 reads as zero.
    always_comb begin
        dout = 32'h0;
        case (addr)
            c_ADDR_CTRL:   dout = {28'h0, r_im, r_mode, r_en};
            c_ADDR_PRESET: dout = w_preset_ext;
            c_ADDR_COUNT:  dout = w_count_ext;
            default:       dout = 32'h0;
        endcase
    end

    assign irq = r_irq_pending & r_im;

endmodule
`default_nettype wire
